// File: rtl/rew_path_encryptor.sv
// rew_path_encryptor: XORs backend bursts with keystream masks, stamps per-bucket IVs into headers, streams to DRAM.
module rew_path_encryptor #(
  parameter int DDRDWidth        = 512,
  parameter int IVEntropyWidth   = 64,
  parameter int BktSize_DRBursts = 4,
  parameter int ORAML            = 3
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [IVEntropyWidth-1:0] CmdPathIV,
  input  logic                      CmdValid,
  output logic                      CmdReady,
  input  logic [DDRDWidth-1:0]      BEDataIn,
  input  logic                      BEDataInValid,
  output logic                      BEDataInReady,
  input  logic [DDRDWidth-1:0]      MaskIn,
  input  logic                      MaskInValid,
  output logic                      MaskInReady,
  output logic [DDRDWidth-1:0]      DRAMWriteData,
  output logic                      DRAMWriteDataValid,
  input  logic                      DRAMWriteDataReady,
  output logic                      PathDone
);
  localparam int BW = BktSize_DRBursts > 1 ? $clog2(BktSize_DRBursts) : 1;
  localparam int LW = ORAML > 0 ? $clog2(ORAML + 1) : 1;
  localparam logic [1:0] ST_Idle   = 2'd0;
  localparam logic [1:0] ST_Stream = 2'd1;
  localparam logic [1:0] ST_Drain  = 2'd2;
  logic [1:0]                state_q, state_d;
  logic [IVEntropyWidth-1:0] base_iv_q, base_iv_d;
  logic [BW-1:0]             burst_cnt_q, burst_cnt_d;
  logic [LW-1:0]             level_cnt_q, level_cnt_d;
  logic [DDRDWidth-1:0]      out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      path_done_q, path_done_d;
  logic                      out_free, streaming, xfer, last_burst, last, cmd_acc, drained;
  logic [DDRDWidth-1:0]      enc, enc_out;
  logic [IVEntropyWidth-1:0] hdr_iv;
  assign out_free   = ~out_valid_q | DRAMWriteDataReady;
  assign streaming  = state_q == ST_Stream;
  assign xfer       = streaming & BEDataInValid & MaskInValid & out_free;
  assign last_burst = burst_cnt_q == BW'(BktSize_DRBursts - 1);
  assign last       = last_burst & (level_cnt_q == LW'(ORAML));
  assign cmd_acc    = (state_q == ST_Idle) & CmdValid;
  assign drained    = (state_q == ST_Drain) & out_valid_q & DRAMWriteDataReady;
  assign enc        = BEDataIn ^ MaskIn;
  // Header IV goes out in plaintext; the masked IV field of the input is dropped.
  assign hdr_iv     = base_iv_q + IVEntropyWidth'(level_cnt_q);
  assign enc_out    = (burst_cnt_q == '0) ? {enc[DDRDWidth-1:IVEntropyWidth], hdr_iv} : enc;
  assign CmdReady           = state_q == ST_Idle;
  assign BEDataInReady      = streaming & MaskInValid & out_free;
  assign MaskInReady        = streaming & BEDataInValid & out_free;
  assign DRAMWriteData      = out_data_q;
  assign DRAMWriteDataValid = out_valid_q;
  assign PathDone           = path_done_q;
  always_comb begin
    state_d     = cmd_acc ? ST_Stream : (xfer & last) ? ST_Drain : drained ? ST_Idle : state_q;
    base_iv_d   = cmd_acc ? CmdPathIV : base_iv_q;
    burst_cnt_d = cmd_acc ? '0 : xfer ? (last_burst ? '0 : burst_cnt_q + BW'(1)) : burst_cnt_q;
    level_cnt_d = (cmd_acc | (xfer & last)) ? '0 : (xfer & last_burst) ? level_cnt_q + LW'(1) : level_cnt_q;
    out_valid_d = xfer | (out_valid_q & ~DRAMWriteDataReady);
    out_data_d  = xfer ? enc_out : out_data_q;
    path_done_d = drained;
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_Idle;
      base_iv_q   <= '0;
      burst_cnt_q <= '0;
      level_cnt_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      path_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_iv_q   <= base_iv_d;
      burst_cnt_q <= burst_cnt_d;
      level_cnt_q <= level_cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      path_done_q <= path_done_d;
    end
  end
endmodule

// File: tb/tb_rew_path_encryptor.sv
// tb_rew_path_encryptor: scoreboard bench for the write-side path encryptor.
module tb_rew_path_encryptor;
  localparam int DW = 512;
  localparam int IW = 64;
  localparam int NB = 16;
  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [IW-1:0] CmdPathIV = '0;
  logic          CmdValid = 1'b0;
  logic          CmdReady;
  logic [DW-1:0] BEDataIn = '0;
  logic          BEDataInValid = 1'b0;
  logic          BEDataInReady;
  logic [DW-1:0] MaskIn = '0;
  logic          MaskInValid = 1'b0;
  logic          MaskInReady;
  logic [DW-1:0] DRAMWriteData;
  logic          DRAMWriteDataValid;
  logic          DRAMWriteDataReady = 1'b1;
  logic          PathDone;
  rew_path_encryptor dut (
    .Clock(Clock), .Reset(Reset),
    .CmdPathIV(CmdPathIV), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .BEDataIn(BEDataIn), .BEDataInValid(BEDataInValid), .BEDataInReady(BEDataInReady),
    .MaskIn(MaskIn), .MaskInValid(MaskInValid), .MaskInReady(MaskInReady),
    .DRAMWriteData(DRAMWriteData), .DRAMWriteDataValid(DRAMWriteDataValid),
    .DRAMWriteDataReady(DRAMWriteDataReady), .PathDone(PathDone)
  );
  always #5 Clock = ~Clock;
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int out_cnt = 0;
  int done_cnt = 0;
  int bp_i = 0;
  bit bp_en = 0;
  logic [DW-1:0] sb[$];
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [DW-1:0] model(input logic [IW-1:0] iv, input int k, input logic [DW-1:0] d, input logic [DW-1:0] m);
    logic [DW-1:0] e;
    e = d ^ m;
    if (k % 4 == 0) e[IW-1:0] = iv + IW'(k / 4);
    return e;
  endfunction
  function automatic logic [DW-1:0] rnd();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction
  always @(posedge Clock) cyc <= cyc + 1;
  always @(negedge Clock) begin
    DRAMWriteDataReady = bp_en ? ((bp_i % 4 == 0) || (bp_i % 4 == 3)) : 1'b1;
    bp_i++;
  end
  logic          pv = 1'b0, pr = 1'b0;
  logic [DW-1:0] pd = '0;
  always @(negedge Clock) begin
    #2;
    if (!Reset) begin
      if (pv && !pr) chk("hold", DRAMWriteData, pd);
      if (DRAMWriteDataValid && DRAMWriteDataReady) begin
        if (sb.size() == 0) chk("extra_out", 1, 0);
        else chk($sformatf("out%0d", out_cnt), DRAMWriteData, sb.pop_front());
        out_cnt++;
      end
      if (PathDone) done_cnt++;
    end
    pv = DRAMWriteDataValid;
    pr = DRAMWriteDataReady;
    pd = DRAMWriteData;
  end
  task automatic send_path(input logic [IW-1:0] iv, input bit basic, input bit starve, input int abort_at,
                           input bit hold, input logic [IW-1:0] iv_next, input bit skip_cmd, input bit timed);
    int cmd_cyc, done_cyc, o0, d0, gap, t, n;
    logic [DW-1:0] d, m;
    bit r, acc, got_done;
    cmd_cyc = 0; done_cyc = 0; gap = 0; got_done = 0;
    o0 = out_cnt; d0 = done_cnt;
    n = abort_at > 0 ? abort_at : NB;
    if (!skip_cmd) begin
      r = 0;
      for (t = 0; t < 20 && !r; t++) begin
        @(negedge Clock);
        CmdValid = 1'b1; CmdPathIV = iv;
        #1 r = CmdReady;
        if (r) cmd_cyc = cyc;
        @(posedge Clock);
      end
      if (!r) begin chk("cmd_timeout", 1, 0); CmdValid = 1'b0; return; end
    end
    for (int k = 0; k < n; k++) begin
      d = basic ? DW'(k) : rnd();
      m = basic ? {DW{1'b1}} : rnd();
      acc = 0;
      for (t = 0; t < 60 && !acc; t++) begin
        @(negedge Clock);
        CmdValid = hold; CmdPathIV = hold ? iv_next : iv;
        BEDataIn = d; MaskIn = m; BEDataInValid = 1'b1;
        MaskInValid = !(starve && k == 6 && gap < 5);
        #1;
        if (!MaskInValid) begin chk("starve_rdy", BEDataInReady, 0); gap++; end
        if (hold) chk("cmd_busy", CmdReady, 0);
        acc = BEDataInValid && MaskInValid && BEDataInReady && MaskInReady;
        @(posedge Clock);
      end
      if (!acc) begin chk("xfer_timeout", 1, 0); BEDataInValid = 0; MaskInValid = 0; CmdValid = 0; return; end
      sb.push_back(model(iv, k, d, m));
    end
    if (abort_at > 0) begin
      @(negedge Clock);
      Reset = 1'b1;
      #1;
      chk("rst_valid", DRAMWriteDataValid, 0);
      chk("rst_data", DRAMWriteData, 0);
      chk("rst_done", PathDone, 0);
      chk("rst_cmdrdy", CmdReady, 1);
      chk("rst_berdy", BEDataInReady, 0);
      chk("rst_mrdy", MaskInReady, 0);
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0; BEDataInValid = 0; MaskInValid = 0;
      sb.delete();
      repeat (4) @(negedge Clock);
      chk("abort_no_done", done_cnt - d0, 0);
      return;
    end
    @(negedge Clock);
    BEDataInValid = 0; MaskInValid = 0;
    for (t = 0; t < 60 && !got_done; t++) begin
      if (t > 0) @(negedge Clock);
      #1;
      if (PathDone) begin
        got_done = 1; done_cyc = cyc;
        if (hold) chk("cmd_rdy_done", CmdReady, 1);
      end else if (hold) chk("cmd_busy", CmdReady, 0);
    end
    if (!got_done) chk("done_timeout", 1, 0);
    @(posedge Clock);
    @(negedge Clock);
    CmdValid = 1'b0;
    repeat (3) @(negedge Clock);
    #3;
    if (timed) chk("path_cycles", done_cyc - cmd_cyc, 18);
    chk("path_outs", out_cnt - o0, NB);
    chk("path_done_once", done_cnt - d0, 1);
    chk("sb_empty", sb.size(), 0);
  endtask
  initial begin
    repeat (3) @(negedge Clock);
    #1;
    chk("init_valid", DRAMWriteDataValid, 0);
    chk("init_data", DRAMWriteData, 0);
    chk("init_done", PathDone, 0);
    chk("init_cmdrdy", CmdReady, 1);
    chk("init_berdy", BEDataInReady, 0);
    chk("init_mrdy", MaskInReady, 0);
    @(negedge Clock);
    Reset = 1'b0;
    send_path(64'h10, 1, 0, 0, 0, 0, 0, 1);
    send_path(64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0, 0, 0);
    send_path(64'h1234_5678_9ABC_DEF0, 0, 1, 0, 0, 0, 0, 0);
    bp_en = 1;
    send_path(64'h55, 0, 0, 0, 0, 0, 0, 0);
    bp_en = 0;
    send_path(64'hA0, 0, 0, 7, 0, 0, 0, 0);
    send_path(64'h200, 1, 0, 0, 0, 0, 0, 1);
    send_path(64'h300, 0, 0, 0, 1, 64'h400, 0, 0);
    send_path(64'h400, 0, 0, 0, 0, 0, 1, 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
